// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA channel arbiter.
package dma_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, XFER, DONE} state_t;

   localparam logic DIR_READ  = 1'b0;
   localparam logic DIR_WRITE = 1'b1;

   localparam int DEF_AW = 6;
   localparam int DEF_LW = 5;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr, wrapping, wins.
module rr_arbiter #(
   parameter int NCH = 3,
   parameter int PW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [PW-1:0]  grant_idx,
   output logic           found
);
   logic [PW-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 0; i < NCH; i++) begin
         idx = PW'((int'(ptr) + i) % NCH);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end
endmodule

// File: rtl/dma_channel_arbiter.sv
// Shares one DMA datapath between NCH channels: round-robin grant, CPU bus-hold
// handshake, burst address walk and a one-cycle per-channel done pulse.
module dma_channel_arbiter
   import dma_pkg::*;
#(
   parameter int NCH = 3,
   parameter int AW  = DEF_AW,
   parameter int LW  = DEF_LW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_dir,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH*LW-1:0] ch_len,
   input  logic              holdack,
   input  logic              hrdy,
   output logic              holdreq,
   output logic [AW-1:0]     addr_out,
   output logic              ramctrl,
   output logic              beat_valid,
   output logic [NCH-1:0]    ch_grant,
   output logic [NCH-1:0]    ch_done,
   output logic              busy
);
   localparam int PW = $clog2(NCH);

   state_t         state;
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  winner;
   logic [LW-1:0]  remaining;
   logic           xfer_en;
   logic [NCH-1:0] pick;
   logic [PW-1:0]  pick_idx;
   logic           pick_found;
   logic [AW-1:0]  addr_arr [NCH];
   logic [LW-1:0]  len_arr  [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_unpack
      assign addr_arr[i] = ch_addr[i*AW +: AW];
      assign len_arr[i]  = ch_len[i*LW +: LW];
   end

   rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr (
      .req       (ch_req),
      .ptr       (ptr),
      .grant     (pick),
      .grant_idx (pick_idx),
      .found     (pick_found)
   );

   // xfer_en only marks "mid-burst"; a beat also needs bus and datapath this very cycle.
   assign beat_valid = xfer_en & holdack & hrdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         winner    <= '0;
         remaining <= '0;
         xfer_en   <= 1'b0;
         addr_out  <= '0;
         ramctrl   <= 1'b0;
         holdreq   <= 1'b0;
         ch_grant  <= '0;
         ch_done   <= '0;
         busy      <= 1'b0;
      end else begin
         ch_done <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  winner    <= pick_idx;
                  ch_grant  <= pick;
                  addr_out  <= addr_arr[pick_idx];
                  remaining <= len_arr[pick_idx];
                  ramctrl   <= ch_dir[pick_idx];
                  busy      <= 1'b1;
                  // A zero-length burst never touches the bus, so the CPU is not asked for it.
                  if (len_arr[pick_idx] != '0) begin
                     state   <= HOLD;
                     holdreq <= 1'b1;
                  end else begin
                     state   <= DONE;
                     ch_done <= pick;
                  end
               end
            end
            HOLD: begin
               if (holdack) begin
                  state   <= XFER;
                  xfer_en <= 1'b1;
               end
            end
            XFER: begin
               if (!holdack) begin
                  state   <= HOLD;
                  xfer_en <= 1'b0;
               end else if (hrdy) begin
                  addr_out  <= addr_out + AW'(1);
                  remaining <= remaining - LW'(1);
                  if (remaining == LW'(1)) begin
                     state   <= DONE;
                     xfer_en <= 1'b0;
                     ch_done <= ch_grant;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               holdreq  <= 1'b0;
               ch_grant <= '0;
               busy     <= 1'b0;
               ptr      <= (winner == PW'(NCH - 1)) ? '0 : winner + PW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: beat/done scoreboard, a table of
// single bursts, and hand-written stall, round-robin and reset sequences.
module tb_dma_channel_arbiter;
   import dma_pkg::*;

   localparam int NCH = 3;
   localparam int AW  = 6;
   localparam int LW  = 5;

   logic              clk;
   logic              rst_n;
   logic [NCH-1:0]    ch_req;
   logic [NCH-1:0]    ch_dir;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*LW-1:0] ch_len;
   logic              holdack;
   logic              hrdy;
   logic              holdreq;
   logic [AW-1:0]     addr_out;
   logic              ramctrl;
   logic              beat_valid;
   logic [NCH-1:0]    ch_grant;
   logic [NCH-1:0]    ch_done;
   logic              busy;

   typedef struct {
      logic [1:0] ch;
      logic [5:0] addr;
      logic       dir;
   } beat_t;

   typedef struct {
      logic [1:0] ch;
      logic [5:0] addr;
      logic       dir;
      logic [4:0] len;
      int         ack_delay;
      logic [5:0] end_addr;
   } vec_t;

   beat_t      exp_beats[$];
   logic [1:0] exp_done[$];
   vec_t       vecs[5];
   int         vectors;
   int         miscompares;
   logic       holdreq_seen;
   logic [5:0] done_addr;

   dma_channel_arbiter #(.NCH(NCH), .AW(AW), .LW(LW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ch_req     (ch_req),
      .ch_dir     (ch_dir),
      .ch_addr    (ch_addr),
      .ch_len     (ch_len),
      .holdack    (holdack),
      .hrdy       (hrdy),
      .holdreq    (holdreq),
      .addr_out   (addr_out),
      .ramctrl    (ramctrl),
      .beat_valid (beat_valid),
      .ch_grant   (ch_grant),
      .ch_done    (ch_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic report_unexpected(input string name, input logic [31:0] actual);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got %0h with nothing expected at %0t", name, actual, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every beat and done pulse the DUT produces is matched against the scoreboard in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (holdreq) holdreq_seen = 1'b1;
         if (beat_valid) begin
            if (exp_beats.size() == 0) report_unexpected("beat_unexpected", 32'(addr_out));
            else begin
               beat_t e;
               e = exp_beats.pop_front();
               check_output("beat_addr", 32'(addr_out), 32'(e.addr));
               check_output("beat_dir", 32'(ramctrl), 32'(e.dir));
               check_output("beat_grant", 32'(ch_grant), 32'(1) << e.ch);
            end
         end
         if (ch_done != '0) begin
            if (exp_done.size() == 0) report_unexpected("done_unexpected", 32'(ch_done));
            else begin
               logic [1:0] c;
               c = exp_done.pop_front();
               check_output("done_onehot", 32'(ch_done), 32'(1) << c);
               check_output("done_busy", 32'(busy), 32'd1);
            end
         end
      end
   end

   task automatic set_channel(input logic [1:0] ch, input logic [5:0] a, input logic d, input logic [4:0] l);
      ch_addr = (ch_addr & ~(18'h3F << (ch * 6))) | (18'(a) << (ch * 6));
      ch_len  = (ch_len & ~(15'h1F << (ch * 5))) | (15'(l) << (ch * 5));
      ch_dir[ch] = d;
   endtask

   task automatic push_expected(input logic [1:0] ch, input logic [5:0] a, input logic d, input logic [4:0] l);
      for (int i = 0; i < int'(l); i++) begin
         beat_t b;
         b.ch   = ch;
         b.addr = a + 6'(i);
         b.dir  = d;
         exp_beats.push_back(b);
      end
      exp_done.push_back(ch);
   endtask

   task automatic wait_done(input logic [1:0] ch, input int limit);
      int n;
      n = 0;
      while (ch_done[ch] !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      check_output("done_pulse", 32'(ch_done), 32'(1) << ch);
      done_addr = addr_out;
   endtask

   task automatic finish_burst(input logic [1:0] ch);
      ch_req[ch] = 1'b0;
      tick();
      check_output("done_one_cycle", 32'(ch_done), 32'd0);
      check_output("holdreq_fall", 32'(holdreq), 32'd0);
      check_output("grant_clear", 32'(ch_grant), 32'd0);
      holdack = 1'b0;
      hrdy    = 1'b0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      int n;
      holdreq_seen = 1'b0;
      push_expected(v.ch, v.addr, v.dir, v.len);
      set_channel(v.ch, v.addr, v.dir, v.len);
      ch_req[v.ch] = 1'b1;
      n = 0;
      while (!holdreq && ch_done == '0 && n < 20) begin
         tick();
         n++;
      end
      if (v.len != '0) begin
         check_output("req_to_holdreq", 32'(n), 32'd1);
         repeat (v.ack_delay) tick();
         holdack = 1'b1;
         hrdy    = 1'b1;
      end
      wait_done(v.ch, 100);
      finish_burst(v.ch);
      if (v.len == '0) check_output("zero_len_holdreq", 32'(holdreq_seen), 32'd0);
      check_output("end_addr", 32'(done_addr), 32'(v.end_addr));
      check_output("beats_drained", 32'(exp_beats.size()), 32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      holdreq_seen = 1'b0;
      done_addr   = '0;
      rst_n   = 1'b0;
      ch_req  = 3'b111;
      ch_dir  = 3'b111;
      ch_addr = 18'h2AAAA;
      ch_len  = 15'h7FFF;
      holdack = 1'b1;
      hrdy    = 1'b1;

      vecs[0] = '{2'd0, 6'h10, DIR_READ,  5'd4,  2, 6'h14};
      vecs[1] = '{2'd2, 6'h20, DIR_WRITE, 5'd1,  0, 6'h21};
      vecs[2] = '{2'd1, 6'h3F, DIR_READ,  5'd3,  1, 6'h02};
      vecs[3] = '{2'd2, 6'h05, DIR_READ,  5'd0,  0, 6'h05};
      vecs[4] = '{2'd0, 6'h00, DIR_WRITE, 5'd31, 3, 6'h1F};

      // Reset held with every channel requesting: nothing may leak out.
      repeat (3) begin
         tick();
         check_output("rst_holdreq", 32'(holdreq), 32'd0);
         check_output("rst_busy", 32'(busy), 32'd0);
         check_output("rst_grant", 32'(ch_grant), 32'd0);
         check_output("rst_addr", 32'(addr_out), 32'd0);
      end
      check_output("rst_ramctrl", 32'(ramctrl), 32'd0);
      check_output("rst_beat", 32'(beat_valid), 32'd0);
      check_output("rst_done", 32'(ch_done), 32'd0);
      ch_req  = '0;
      holdack = 1'b0;
      hrdy    = 1'b0;
      rst_n   = 1'b1;
      tick();
      check_output("post_rst_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

      // Stall on hrdy, then lose the bus mid-burst across the address wrap.
      push_expected(2'd1, 6'h3E, DIR_WRITE, 5'd4);
      set_channel(2'd1, 6'h3E, DIR_WRITE, 5'd4);
      ch_req[1] = 1'b1;
      tick();
      check_output("stall_holdreq_rise", 32'(holdreq), 32'd1);
      tick();
      tick();
      holdack = 1'b1;
      hrdy    = 1'b1;
      repeat (3) tick();
      hrdy = 1'b0;
      repeat (3) begin
         tick();
         check_output("stall_holdreq", 32'(holdreq), 32'd1);
      end
      check_output("stall_addr_hold", 32'(addr_out), 32'h00);
      hrdy = 1'b1;
      tick();
      holdack = 1'b0;
      tick();
      tick();
      check_output("drop_holdreq", 32'(holdreq), 32'd1);
      check_output("drop_busy", 32'(busy), 32'd1);
      check_output("drop_addr_kept", 32'(addr_out), 32'h01);
      holdack = 1'b1;
      wait_done(2'd1, 20);
      check_output("stall_end_addr", 32'(done_addr), 32'h02);
      finish_burst(2'd1);

      // Fresh pointer, all channels requesting continuously.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_channel(2'd0, 6'h01, DIR_READ,  5'd1);
      set_channel(2'd1, 6'h11, DIR_WRITE, 5'd1);
      set_channel(2'd2, 6'h21, DIR_READ,  5'd1);
      push_expected(2'd0, 6'h01, DIR_READ,  5'd1);
      push_expected(2'd1, 6'h11, DIR_WRITE, 5'd1);
      push_expected(2'd2, 6'h21, DIR_READ,  5'd1);
      push_expected(2'd0, 6'h01, DIR_READ,  5'd1);
      holdack = 1'b1;
      hrdy    = 1'b1;
      ch_req  = 3'b111;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] who;
         who = 2'(k % 3);
         wait_done(who, 20);
         if (k == 3) ch_req = '0;
         tick();
         check_output("rr_idle_gap", 32'(busy), 32'd0);
      end
      holdack = 1'b0;
      hrdy    = 1'b0;

      // Reset lands during beat 2 of an 8-beat burst; the request then restarts cleanly.
      begin
         beat_t b;
         b.ch   = 2'd0;
         b.addr = 6'h08;
         b.dir  = DIR_READ;
         exp_beats.push_back(b);
      end
      set_channel(2'd0, 6'h08, DIR_READ, 5'd8);
      holdack   = 1'b1;
      hrdy      = 1'b1;
      ch_req[0] = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check_output("abort_holdreq", 32'(holdreq), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_grant", 32'(ch_grant), 32'd0);
      check_output("abort_beat", 32'(beat_valid), 32'd0);
      check_output("abort_done", 32'(ch_done), 32'd0);
      check_output("abort_scoreboard", 32'(exp_beats.size()), 32'd0);
      tick();
      tick();
      push_expected(2'd0, 6'h08, DIR_READ, 5'd8);
      rst_n = 1'b1;
      wait_done(2'd0, 40);
      check_output("restart_end_addr", 32'(done_addr), 32'h10);
      finish_burst(2'd0);

      tick();
      check_output("final_beats_left", 32'(exp_beats.size()), 32'd0);
      check_output("final_done_left", 32'(exp_done.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
